// File: rtl/rr_channel_mux.sv
// N-channel valid/ready selector with fixed or round-robin grant and a single
// registered output stage; each output word carries its source channel number.
module rr_channel_mux #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MODE,
    input  logic [SELW-1:0]           SEL,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_VALID,
    output logic [CHANNELS-1:0]       IN_READY,
    output logic [WIDTH-1:0]          OUT,
    output logic [SELW-1:0]           OUT_CH,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  last_q, last_d;

    logic             load_en;
    logic             fix_hit;
    logic             rr_hit;
    logic [SELW-1:0]  rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    assign load_en = !out_valid_q || OUT_READY;

    // Compare against every legal index so an out-of-range SEL simply finds nothing.
    always_comb begin
        fix_hit = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL == SELW'(k) && IN_VALID[k]) begin
                fix_hit = 1'b1;
            end
        end
    end

    // Search starts just after the last source and wraps at CHANNELS, not 2^SELW.
    always_comb begin
        int cand;
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = int'(last_q) + 1 + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (!rr_hit && IN_VALID[cand]) begin
                rr_hit = 1'b1;
                rr_idx = SELW'(cand);
            end
        end
    end

    assign grant_vld = MODE ? rr_hit : fix_hit;
    assign grant_idx = MODE ? rr_idx : SEL;
    assign xfer      = grant_vld && load_en;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign IN_READY[gi] = !RST && xfer && (grant_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SELW'(k)) begin
                grant_data = IN_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_d       = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            last_d      = grant_idx;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(CHANNELS - 1);
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_rr_channel_mux.sv
// Self-checking bench: a 4-channel and a 3-channel instance, hand tables,
// corner sequences and randomized traffic against a behavioural model.
module tb_rr_channel_mux;

    logic        clk, rst;
    logic        mode4, mode3;
    logic [1:0]  sel4, sel3;
    logic [63:0] data4;
    logic [47:0] data3;
    logic [3:0]  vld4, rdy4;
    logic [2:0]  vld3, rdy3;
    logic [15:0] out4, out3;
    logic [1:0]  ch4, ch3;
    logic        ov4, ov3, ordy4, ordy3;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state, index 0 = 4-channel DUT, index 1 = 3-channel DUT.
    int          m_last  [2];
    logic [15:0] m_out   [2];
    int          m_ch    [2];
    bit          m_valid [2];

    rr_channel_mux #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
        .CLK(clk), .RST(rst), .MODE(mode4), .SEL(sel4), .IN_DATA(data4),
        .IN_VALID(vld4), .IN_READY(rdy4), .OUT(out4), .OUT_CH(ch4),
        .OUT_VALID(ov4), .OUT_READY(ordy4)
    );

    rr_channel_mux #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
        .CLK(clk), .RST(rst), .MODE(mode3), .SEL(sel3), .IN_DATA(data3),
        .IN_VALID(vld3), .IN_READY(rdy3), .OUT(out3), .OUT_CH(ch3),
        .OUT_VALID(ov3), .OUT_READY(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int ref_grant(input int n, input bit mode, input int sel,
                                     input logic [3:0] valid, input int last);
        if (!mode) begin
            if (sel < n) begin
                if (valid[sel]) return sel;
            end
            return -1;
        end
        for (int i = 1; i <= n; i++) begin
            if (valid[(last + i) % n]) return (last + i) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last[0] = 3; m_last[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 16'h0; m_ch[d] = 0; m_valid[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input int d, input int g, input bit xf, input bit ordy,
                              input logic [63:0] data);
        if (xf) begin
            m_out[d]   = data[g*16 +: 16];
            m_ch[d]    = g;
            m_valid[d] = 1'b1;
            m_last[d]  = g;
        end else if (m_valid[d] && ordy) begin
            m_valid[d] = 1'b0;
        end
    endtask

    // One clock: check IN_READY before the edge, advance the model, check outputs after.
    task automatic step();
        int g4, g3;
        bit x4, x3;
        #1;
        g4 = ref_grant(4, mode4, int'(sel4), vld4, m_last[0]);
        g3 = ref_grant(3, mode3, int'(sel3), {1'b0, vld3}, m_last[1]);
        x4 = (g4 >= 0) && (!m_valid[0] || ordy4);
        x3 = (g3 >= 0) && (!m_valid[1] || ordy3);
        check("ready4", {28'h0, rdy4}, x4 ? (32'h1 << g4) : 32'h0);
        check("ready3", {29'h0, rdy3}, x3 ? (32'h1 << g3) : 32'h0);
        @(posedge clk);
        #1;
        model_edge(0, g4, x4, ordy4, data4);
        model_edge(1, g3, x3, ordy3, {16'h0, data3});
        check("out4",   {16'h0, out4}, {16'h0, m_out[0]});
        check("ch4",    {30'h0, ch4},  m_ch[0]);
        check("valid4", {31'h0, ov4},  {31'h0, m_valid[0]});
        check("out3",   {16'h0, out3}, {16'h0, m_out[1]});
        check("ch3",    {30'h0, ch3},  m_ch[1]);
        check("valid3", {31'h0, ov3},  {31'h0, m_valid[1]});
    endtask

    typedef struct {
        bit         mode;
        logic [1:0] sel;
        logic [3:0] valid;
        bit         ordy;
        logic [3:0] exp_ready;
        logic [15:0] exp_out;
        int          exp_ch;
        bit          exp_valid;
    } vec_t;

    vec_t vecs [29];

    initial begin
        // Fixed-mode SEL stepping
        vecs[0]  = '{0, 0, 4'hF, 1, 4'b0001, 16'h0001, 0, 1};
        vecs[1]  = '{0, 0, 4'hF, 1, 4'b0001, 16'h0001, 0, 1};
        vecs[2]  = '{0, 1, 4'hF, 1, 4'b0010, 16'h0002, 1, 1};
        vecs[3]  = '{0, 2, 4'hF, 1, 4'b0100, 16'h0003, 2, 1};
        vecs[4]  = '{0, 3, 4'hF, 1, 4'b1000, 16'h0004, 3, 1};
        // Round robin, all valid, then channel 1 dropped
        vecs[5]  = '{1, 0, 4'hF, 1, 4'b0001, 16'h0001, 0, 1};
        vecs[6]  = '{1, 0, 4'hF, 1, 4'b0010, 16'h0002, 1, 1};
        vecs[7]  = '{1, 0, 4'hF, 1, 4'b0100, 16'h0003, 2, 1};
        vecs[8]  = '{1, 0, 4'hF, 1, 4'b1000, 16'h0004, 3, 1};
        vecs[9]  = '{1, 0, 4'hF, 1, 4'b0001, 16'h0001, 0, 1};
        vecs[10] = '{1, 0, 4'hD, 1, 4'b0100, 16'h0003, 2, 1};
        vecs[11] = '{1, 0, 4'hD, 1, 4'b1000, 16'h0004, 3, 1};
        vecs[12] = '{1, 0, 4'hD, 1, 4'b0001, 16'h0001, 0, 1};
        vecs[13] = '{1, 0, 4'hD, 1, 4'b0100, 16'h0003, 2, 1};
        // Backpressure for 5 cycles holding 0x0003, then release
        for (int i = 14; i < 19; i++) vecs[i] = '{1, 0, 4'hD, 0, 4'b0000, 16'h0003, 2, 1};
        vecs[19] = '{1, 0, 4'hD, 1, 4'b1000, 16'h0004, 3, 1};
        // Drain with nothing offered
        vecs[20] = '{1, 0, 4'h0, 1, 4'b0000, 16'h0004, 3, 0};
        vecs[21] = '{1, 0, 4'h0, 0, 4'b0000, 16'h0004, 3, 0};
        // Mode switch: fixed SEL=2 updates last, round robin resumes at 3
        vecs[22] = '{0, 2, 4'hF, 1, 4'b0100, 16'h0003, 2, 1};
        vecs[23] = '{1, 2, 4'hF, 1, 4'b1000, 16'h0004, 3, 1};
        // Stall, release, stall with no input, drain, load into empty register while stalled
        vecs[24] = '{0, 1, 4'hF, 0, 4'b0000, 16'h0004, 3, 1};
        vecs[25] = '{0, 1, 4'hF, 1, 4'b0010, 16'h0002, 1, 1};
        vecs[26] = '{0, 1, 4'h0, 0, 4'b0000, 16'h0002, 1, 1};
        vecs[27] = '{0, 1, 4'h0, 1, 4'b0000, 16'h0002, 1, 0};
        vecs[28] = '{0, 0, 4'hF, 0, 4'b0001, 16'h0001, 0, 1};

        rst = 1'b1;
        mode4 = 1'b1; sel4 = 2'd0; vld4 = 4'hF; ordy4 = 1'b1;
        data4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        mode3 = 1'b1; sel3 = 2'd0; vld3 = 3'h7; ordy3 = 1'b1;
        data3 = {16'h0012, 16'h0011, 16'h0010};
        model_reset();
        #3;
        check("rst_out4",   {16'h0, out4}, 32'h0);
        check("rst_valid4", {31'h0, ov4},  32'h0);
        check("rst_ch4",    {30'h0, ch4},  32'h0);
        check("rst_ready4", {28'h0, rdy4}, 32'h0);
        check("rst_ready3", {29'h0, rdy3}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_ready4_hold", {28'h0, rdy4}, 32'h0);
        rst = 1'b0;
        vld3 = 3'h0;

        for (int i = 0; i < 29; i++) begin
            mode4 = vecs[i].mode; sel4 = vecs[i].sel;
            vld4 = vecs[i].valid; ordy4 = vecs[i].ordy;
            #1;
            check($sformatf("tbl%0d_ready", i), {28'h0, rdy4}, {28'h0, vecs[i].exp_ready});
            step();
            check($sformatf("tbl%0d_out", i),   {16'h0, out4}, {16'h0, vecs[i].exp_out});
            check($sformatf("tbl%0d_ch", i),    {30'h0, ch4},  vecs[i].exp_ch);
            check($sformatf("tbl%0d_valid", i), {31'h0, ov4},  {31'h0, vecs[i].exp_valid});
            $display("vec %0d: mode=%0d sel=%0d valid=%b ordy=%0d -> out=%h ch=%0d ov=%0d",
                     i, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy, out4, ch4, ov4);
        end

        // 3-channel: out-of-range SEL gives no grant and the held word drains
        mode3 = 1'b0; sel3 = 2'd1; vld3 = 3'h7; ordy3 = 1'b0;
        step();
        check("c3_load_ch", {30'h0, ch3}, 32'd1);
        sel3 = 2'd3;
        step();
        check("c3_sel3_hold", {31'h0, ov3}, 32'd1);
        ordy3 = 1'b1;
        #1;
        check("c3_sel3_ready", {29'h0, rdy3}, 32'h0);
        step();
        check("c3_sel3_drain", {31'h0, ov3}, 32'd0);
        check("c3_sel3_out", {16'h0, out3}, 32'h0011);
        step();
        // Round robin wraps 2 -> 0 at three channels
        mode3 = 1'b1;
        step();
        check("c3_rr_ch2", {30'h0, ch3}, 32'd2);
        step();
        check("c3_rr_wrap", {30'h0, ch3}, 32'd0);
        $display("c3 sequence: out=%h ch=%0d ov=%0d", out3, ch3, ov3);

        // Asynchronous reset between edges while a word is held
        mode4 = 1'b1; vld4 = 4'hF; ordy4 = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("amid_valid4", {31'h0, ov4},  32'h0);
        check("amid_out4",   {16'h0, out4}, 32'h0);
        check("amid_ch4",    {30'h0, ch4},  32'h0);
        check("amid_valid3", {31'h0, ov3},  32'h0);
        check("amid_ready4", {28'h0, rdy4}, 32'h0);
        @(posedge clk);
        #1;
        check("amid_hold_valid4", {31'h0, ov4}, 32'h0);
        rst = 1'b0;
        model_reset();
        ordy4 = 1'b1;
        step();
        check("after_rst_ch4", {30'h0, ch4}, 32'd0);
        check("after_rst_out4", {16'h0, out4}, 32'h0001);
        $display("reset sequence: out=%h ch=%0d ov=%0d", out4, ch4, ov4);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            mode4 = 1'($urandom); sel4 = 2'($urandom); vld4 = 4'($urandom);
            ordy4 = ($urandom % 4) != 0; data4 = {$urandom, $urandom};
            mode3 = 1'($urandom); sel3 = 2'($urandom); vld3 = 3'($urandom);
            ordy3 = ($urandom % 4) != 0; data3 = {16'($urandom), $urandom};
            step();
            $display("rnd %0d: out4=%h ch4=%0d ov4=%0d out3=%h ch3=%0d ov3=%0d",
                     c, out4, ch4, ov4, out3, ch3, ov3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_channel_mux.md
# rr_channel_mux

Parametrised N-channel, WIDTH-bit channel selector with valid/ready handshaking and a registered output stage. It replaces the fixed 4:1 combinational 16-bit mux wherever several producers share one consumer. In fixed mode the block forwards the channel picked by SEL. In round-robin mode it arbitrates fairly among all channels that have data. Each output word is tagged with its source channel number.

## Interface
- WIDTH, 16: data width of every channel and of OUT.
- CHANNELS, 4: number of input channels; range 2..16, and need not be a power of two.
- SELW (localparam), $clog2(CHANNELS): width of SEL and OUT_CH.

- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- SEL  input  SELW  channel index used in fixed mode; ignored in round-robin mode.
- IN_DATA  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- IN_VALID  input  CHANNELS  per-channel valid.
- IN_READY  output  CHANNELS  per-channel ready; at most one bit high, combinational.
- OUT  output  WIDTH  registered output data.
- OUT_CH  output  SELW  source channel of OUT.
- OUT_VALID  output  1  OUT holds an unconsumed word.
- OUT_READY  input  1  consumer accepts OUT.

## Operation
- Single output holding register: OUT, OUT_CH, OUT_VALID.
- load_en = !OUT_VALID || OUT_READY.
- Grant g is computed combinationally each cycle.
  - Fixed mode: g = SEL if SEL < CHANNELS and IN_VALID[SEL]; otherwise no grant.
  - Round-robin mode: g is the first channel with IN_VALID set, searching from last+1 and wrapping modulo CHANNELS (not modulo 2^SELW). No grant if no channel is valid.
- IN_READY[g] = load_en when a grant exists; all other IN_READY bits are 0.
- IN_READY never depends on IN_VALID of the granted channel's neighbours beyond the grant search. No combinational path from OUT_READY to OUT.
- Transfer on channel g occurs when IN_VALID[g] && IN_READY[g]. On the next edge:
  - OUT <= IN_DATA[g]
  - OUT_CH <= g
  - OUT_VALID <= 1
  - last <= g (updated in both modes, so a mode switch resumes rotation from the most recent source)
- Drain without a new transfer (OUT_VALID && OUT_READY, no grant): OUT_VALID <= 0. OUT and OUT_CH keep their old values.
- Drain and transfer in the same cycle: the new word replaces the old one and OUT_VALID stays 1. No bubble.
- Stall (OUT_VALID && !OUT_READY): OUT, OUT_CH and OUT_VALID hold. All IN_READY bits are 0.
- Changes to MODE or SEL affect only the next grant and never alter a held word.
- SEL >= CHANNELS (non-power-of-two CHANNELS) is a legal input: no grant, no transfer, no X propagation.

## Timing
- Reset values (asynchronous, applied immediately on RST high):
  - OUT = 0, OUT_CH = 0, OUT_VALID = 0
  - last = CHANNELS-1, so channel 0 has first round-robin priority
  - IN_READY = 0 for the whole time RST is high
- Latency: input transfer at edge n appears on OUT with OUT_VALID at edge n+1 (1 cycle).
- Throughput: 1 word per cycle while OUT_READY is held high.
- Round-robin fairness: when all channels stay valid and OUT_READY stays high, grants cycle 0,1,...,CHANNELS-1,0,... with no channel repeated before all others have been served.
- RST asserted mid-stream: the held word is discarded and OUT_VALID drops in the same cycle. The first grant after RST deasserts goes to channel 0 in round-robin mode.

## Test plan
- Fixed mode (WIDTH=16, CHANNELS=4, inputs 0x0001/0x0002/0x0003/0x0004, all valid, OUT_READY=1), SEL stepped 0→3 every 10 cycles -> OUT = 0x0001..0x0004 one cycle after each step, OUT_CH = SEL, only IN_READY[SEL] high.
- Round-robin mode, all four channels valid, OUT_READY=1 -> OUT sequence 0001, 0002, 0003, 0004, 0001, ... on consecutive cycles. Then drop IN_VALID[1] -> sequence skips 0002 without any bubble.
- Backpressure: OUT_READY=0 for 5 cycles with OUT=0x0003 held -> OUT, OUT_CH=2 and OUT_VALID stable, IN_READY=0000. On release, the next word appears the following cycle with no loss or duplication.
- CHANNELS=3, MODE=0, SEL=3 -> IN_READY=000, OUT_VALID falls after the current word drains, no X on any output. Round-robin wraps 2→0.
- Reset mid-stream: assert RST asynchronously between edges while OUT_VALID=1 -> OUT_VALID=0 and OUT=0 immediately. After deassertion, the first round-robin grant goes to channel 0.
- Mode switch: MODE=0 with SEL=2 transfers 0x0003, then MODE=1 -> next grant is channel 3 (0x0004), confirming last was updated in fixed mode.
